adc_temp_reader: RTL and testbench
==================================

Name: adc_temp_reader

Overview:
Upstream acquisition stage for the temperature/fan/alarm display unit. Drives a 12-bit serial ADC (16-bit frame: 4 leading zeros + 12 data bits, MSB first) over SPI and samples one temperature reading per period. Converts each reading to the 5-bit `temperatura` code and pulses `lect` for one cycle. The downstream FSM/7-segment unit consumes both signals directly.

Parameters:
- CLK_DIV, 4, `clock` cycles per `sclk` half-period; must be >= 2.
- SAMPLE_PERIOD, 1000000, `clock` cycles from the end of one frame (`lect` pulse) to the next `cs_n` fall; must be >= 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en_m1  in  1  acquisition enable; level-sensitive.
- sdata  in  1  ADC serial data; ADC changes it after `sclk` falls.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  SPI clock; idles high.
- temperatura  out  5  last valid temperature code.
- lect  out  1  one-cycle strobe: new frame finished.
- frame_err  out  1  one-cycle strobe with `lect`: leading bits were not zero.

Behaviour:
- All outputs are registered.
- Reset (`reset` = 0 at a clock edge):
  - `cs_n` = 1, `sclk` = 1, `temperatura` = 0, `lect` = 0, `frame_err` = 0.
  - state = IDLE; all counters and the shift register = 0.
  - Reset overrides everything and aborts a frame in progress immediately: `cs_n` returns to 1 the next cycle and no `lect` is produced.
- States: IDLE, SETUP, SHIFT, QUIET, DONE, WAIT.
- IDLE:
  - `cs_n` = 1, `sclk` = 1.
  - If `en_m1` = 1, go to SETUP; `cs_n` falls on that same edge (cycle T).
- SETUP:
  - `cs_n` = 0, `sclk` = 1, held for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - 16 bit periods, each 2*CLK_DIV cycles: `sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `sdata` is shifted into a 16-bit register, MSB first, on the edge where `sclk` goes 0->1.
  - Go to QUIET at the end of the 16th high phase.
  - A bit counter (0..15) and a divider counter (0..CLK_DIV-1) control this state.
- QUIET:
  - `cs_n` = 1, `sclk` = 1, held for CLK_DIV cycles, then go to DONE.
- DONE (one cycle):
  - `lect` = 1 for exactly this cycle.
  - If shift[15:12] == 0: `temperatura` <= shift[11:7] (the 5 MSBs of the 12-bit code, truncation, no rounding) and `frame_err` = 0.
  - Otherwise: `temperatura` holds its previous value and `frame_err` = 1 in the same cycle as `lect`.
  - Next state is WAIT.
- Latency: `lect` is high in cycle T + 34*CLK_DIV, which is T+136 for the default CLK_DIV.
- WAIT:
  - Counts SAMPLE_PERIOD cycles (counter width is ceil(log2(SAMPLE_PERIOD)) bits).
  - On terminal count: go to SETUP if `en_m1` = 1, else IDLE.
  - If `en_m1` = 0 at any cycle in WAIT, go to IDLE at once and clear the counter.
- `en_m1` falling during SETUP, SHIFT or QUIET: the frame completes normally, including `lect`. The block then goes WAIT -> IDLE.
- `en_m1` rising during WAIT cannot occur, since WAIT exits when `en_m1` = 0. Re-enable from IDLE starts a frame immediately.
- `temperatura` is stable between `lect` strobes.
- `sclk` never glitches: it changes only on divider terminal count, and only in SHIFT.
- `cs_n` is low only in SETUP and SHIFT.

Decomposition:
- Shared package `adc_temp_pkg`:
  - state encoding (localparams for IDLE..WAIT);
  - FRAME_BITS = 16, LEAD_BITS = 4, DATA_BITS = 12, TEMP_BITS = 5;
  - TEMP_LSB = DATA_BITS - TEMP_BITS = 7.
- One sub-module, `spi_clk_div`:
  - parameter CLK_DIV;
  - inputs `clock`, `reset`, `run`;
  - outputs `sclk` and a one-cycle `rise` strobe, used as the sample enable.
- The parent holds the FSM, bit counter, shift register, WAIT counter and output registers.

Test Plan:
- Reset values: hold `reset` = 0 for 5 cycles with `en_m1` = 1 and random `sdata` -> `cs_n` = 1, `sclk` = 1, `temperatura` = 0, `lect` = 0, `frame_err` = 0 throughout.
- Nominal frame (CLK_DIV = 4): ADC model returns 0x0ABC; release reset with `en_m1` = 1; `cs_n` falls at T -> exactly 16 `sclk` rising edges; `lect` = 1 only at T+136; `temperatura` = 5'd21 (0xABC[11:7] = 10101); `frame_err` = 0.
- Bounds: frames 0x0FFF then 0x007F -> `temperatura` = 31, then 0; each frame has one `lect` pulse.
- Framing error: after a valid 21, a frame of 0x8ABC -> `lect` and `frame_err` both high in the same cycle; `temperatura` stays 21.
- Enable handling (SAMPLE_PERIOD = 50):
  - with `en_m1` held at 1, consecutive `cs_n` falls are 136+1+50 cycles apart;
  - with `en_m1` dropped at bit 5 of a frame, the frame still completes with `lect`, then the block returns to IDLE and no further `cs_n` fall occurs.
- Reset mid-frame: assert `reset` = 0 during bit 8 -> next cycle `cs_n` = 1, `sclk` = 1, no `lect`, `temperatura` = 0; after release with `en_m1` = 1, a fresh full 16-bit frame starts.

Source files
------------

// File: rtl/adc_temp_pkg.sv
// rtl/adc_temp_pkg.sv - frame geometry and FSM state encoding for the ADC temperature reader
package adc_temp_pkg;

   localparam int FRAME_BITS = 16;
   localparam int LEAD_BITS  = 4;
   localparam int DATA_BITS  = 12;
   localparam int TEMP_BITS  = 5;
   localparam int TEMP_LSB   = DATA_BITS - TEMP_BITS;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      QUIET = 3'd3,
      DONE  = 3'd4,
      WAIT  = 3'd5
   } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SPI clock divider; sclk idles high and toggles every CLK_DIV cycles while run is high
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic sclk,
   output logic rise
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          sclk_q;
   logic          tc;

   assign tc   = run && (cnt_q == CNT_LAST);
   // rise marks the edge on which sclk goes 0->1, so the parent samples on that same edge
   assign rise = tc && !sclk_q;
   assign sclk = sclk_q;

   always_ff @(posedge clock) begin
      if (!reset || !run) begin
         cnt_q  <= '0;
         sclk_q <= 1'b1;
      end else if (tc) begin
         cnt_q  <= '0;
         sclk_q <= ~sclk_q;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/adc_temp_reader.sv
// rtl/adc_temp_reader.sv - periodic SPI ADC read, 5-bit temperature code with lect/frame_err strobes
module adc_temp_reader
   import adc_temp_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en_m1,
   input  logic                 sdata,
   output logic                 cs_n,
   output logic                 sclk,
   output logic [TEMP_BITS-1:0] temperatura,
   output logic                 lect,
   output logic                 frame_err
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int WW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(SAMPLE_PERIOD - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

   state_e                 state_q;
   logic [PW-1:0]          phase_q;
   logic [BW-1:0]          bit_q;
   logic                   last_q;
   logic [FRAME_BITS-1:0]  shift_q;
   logic [WW-1:0]          wait_q;
   logic                   cs_n_q;
   logic                   lect_q;
   logic                   err_q;
   logic [TEMP_BITS-1:0]   temp_q;
   logic                   run;
   logic                   rise;
   logic                   phase_tc;
   logic                   unused_low_bits;

   // Divider stops after the 16th rise so sclk stays high through the final high phase and QUIET
   assign run      = (state_q == SETUP) || ((state_q == SHIFT) && !last_q);
   assign phase_tc = (phase_q == PHASE_LAST);
   assign unused_low_bits = ^shift_q[TEMP_LSB-1:0];

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_spi_clk_div (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .sclk  (sclk),
      .rise  (rise)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         last_q  <= 1'b0;
         shift_q <= '0;
         wait_q  <= '0;
         cs_n_q  <= 1'b1;
         lect_q  <= 1'b0;
         err_q   <= 1'b0;
         temp_q  <= '0;
      end else begin
         lect_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               cs_n_q <= 1'b1;
               if (en_m1) begin
                  state_q <= SETUP;
                  cs_n_q  <= 1'b0;
               end
            end
            SETUP: begin
               if (phase_tc) begin
                  phase_q <= '0;
                  state_q <= SHIFT;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            SHIFT: begin
               if (rise) begin
                  shift_q <= {shift_q[FRAME_BITS-2:0], sdata};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     last_q <= 1'b1;
                  end
               end
               if (last_q) begin
                  if (phase_tc) begin
                     phase_q <= '0;
                     last_q  <= 1'b0;
                     state_q <= QUIET;
                     cs_n_q  <= 1'b1;
                  end else begin
                     phase_q <= phase_q + 1'b1;
                  end
               end
            end
            QUIET: begin
               if (phase_tc) begin
                  phase_q <= '0;
                  state_q <= DONE;
                  lect_q  <= 1'b1;
                  // A non-zero lead nibble means a corrupted frame: keep the last good reading
                  if (shift_q[FRAME_BITS-1 -: LEAD_BITS] == '0) begin
                     temp_q <= shift_q[TEMP_LSB +: TEMP_BITS];
                  end else begin
                     err_q <= 1'b1;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= WAIT;
               wait_q  <= '0;
            end
            WAIT: begin
               if (!en_m1) begin
                  state_q <= IDLE;
                  wait_q  <= '0;
               end else if (wait_q == WAIT_LAST) begin
                  wait_q  <= '0;
                  state_q <= SETUP;
                  cs_n_q  <= 1'b0;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_n_q  <= 1'b1;
            end
         endcase
      end
   end

   assign cs_n        = cs_n_q;
   assign lect        = lect_q;
   assign frame_err   = err_q;
   assign temperatura = temp_q;

endmodule

// File: tb/tb_adc_temp_reader.sv
// tb/tb_adc_temp_reader.sv - scoreboard bench for adc_temp_reader with a serial ADC model
module tb_adc_temp_reader;

   typedef struct {
      logic [4:0] temp;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en_m1 = 1'b0;
   logic       sdata = 1'b0;
   logic       cs_n;
   logic       sclk;
   logic [4:0] temperatura;
   logic       lect;
   logic       frame_err;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lect_cnt = 0;
   int          rises = 0;
   int          bit_idx = 0;
   int          k;
   logic [15:0] cur_word = 16'h0000;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b1;
   int          fall_times[$];
   logic [15:0] adc_q[$];
   exp_t        exp_q[$];
   exp_t        e;

   logic [15:0] words    [6] = '{16'h0ABC, 16'h0FFF, 16'h007F, 16'h0ABC, 16'h8ABC, 16'h0500};
   logic [4:0]  exp_temp [6] = '{5'd21, 5'd31, 5'd0, 5'd21, 5'd21, 5'd10};
   logic        exp_err  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;

   adc_temp_reader #(
      .CLK_DIV       (4),
      .SAMPLE_PERIOD (50)
   ) dut (
      .clock       (clk),
      .reset       (reset),
      .en_m1       (en_m1),
      .sdata       (sdata),
      .cs_n        (cs_n),
      .sclk        (sclk),
      .temperatura (temperatura),
      .lect        (lect),
      .frame_err   (frame_err)
   );

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ADC model, frame timing and scoreboard monitor
   always @(negedge clk) begin
      cyc++;
      if (!reset) sdata = 1'($urandom_range(0, 1));
      if (prev_cs && !cs_n) begin
         fall_times.push_back(cyc);
         cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
         bit_idx  = 0;
         rises    = 0;
      end
      if (!cs_n && prev_sclk && !sclk && bit_idx < 16) begin
         sdata = cur_word[15 - bit_idx];
         bit_idx++;
      end
      if (!cs_n && !prev_sclk && sclk) rises++;
      if (frame_err && !lect) check_eq("err_without_lect", 32'(frame_err), 0);
      if (lect) begin
         lect_cnt++;
         check_eq("lect_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("temperatura", 32'(temperatura), 32'(e.temp));
            check_eq("frame_err", 32'(frame_err), 32'(e.err));
            check_eq("sclk_rises", rises, 16);
            check_eq("lect_latency", cyc - fall_times[fall_times.size() - 1], 136);
         end
      end
      prev_cs   = cs_n;
      prev_sclk = sclk;
   end

   initial begin
      reset = 1'b0;
      en_m1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check_eq("reset_outputs", 32'({cs_n, sclk, temperatura, lect, frame_err}), 32'h180);
      end

      for (int i = 0; i < 6; i++) begin
         adc_q.push_back(words[i]);
         exp_q.push_back('{exp_temp[i], exp_err[i]});
      end
      reset = 1'b1;

      k = 0;
      while (lect_cnt < 5 && k < 1500) begin @(negedge clk); #1; k++; end
      check_eq("five_frames_done", lect_cnt, 5);
      if (fall_times.size() >= 5) begin
         for (int i = 0; i < 4; i++)
            check_eq("frame_spacing", fall_times[i+1] - fall_times[i], 187);
      end

      k = 0;
      while (!(fall_times.size() >= 6 && rises >= 5) && k < 300) begin @(negedge clk); #1; k++; end
      check_eq("frame6_bit5_reached", 32'(fall_times.size() >= 6 && rises >= 5), 1);
      en_m1 = 1'b0;
      k = 0;
      while (lect_cnt < 6 && k < 300) begin @(negedge clk); #1; k++; end
      check_eq("lect_after_disable", lect_cnt, 6);
      repeat (200) @(negedge clk);
      #1;
      check_eq("no_restart_when_disabled", fall_times.size(), 6);
      check_eq("idle_pins", 32'({cs_n, sclk}), 3);
      check_eq("temp_held", 32'(temperatura), 10);

      adc_q.push_back(16'h0123);
      en_m1 = 1'b1;
      k = 0;
      while (!(fall_times.size() >= 7 && rises >= 8) && k < 300) begin @(negedge clk); #1; k++; end
      check_eq("abort_bit8_reached", 32'(fall_times.size() >= 7 && rises >= 8), 1);
      reset = 1'b0;
      @(negedge clk); #1;
      check_eq("reset_abort_outputs", 32'({cs_n, sclk, temperatura, lect, frame_err}), 32'h180);
      @(negedge clk); #1;
      check_eq("reset_abort_no_lect", lect_cnt, 6);
      adc_q.push_back(16'h0C80);
      exp_q.push_back('{5'd25, 1'b0});
      reset = 1'b1;
      k = 0;
      while (lect_cnt < 7 && k < 300) begin @(negedge clk); #1; k++; end
      check_eq("fresh_frame_lect", lect_cnt, 7);
      check_eq("fresh_frame_started", fall_times.size(), 8);
      en_m1 = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check_eq("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
